// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite slave memory: response codes and channel FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decode: byte address + prot -> word index and OKAY/SLVERR.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                      P_DATA_WIDTH = 32,
  parameter int                      P_ADDR_WIDTH = 32,
  parameter int                      P_DEPTH      = 256,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE_ADDR  = '0,
  parameter int                      P_PROT_CHECK = 0,
  localparam int                     IDX_W        = $clog2(P_DEPTH)
) (
  input  logic [P_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]              prot,
  output logic [IDX_W-1:0]        index,
  output resp_t                   resp
);
  localparam int LSB = $clog2(P_DATA_WIDTH / 8);

  logic [P_ADDR_WIDTH-1:0] offset;
  logic [P_ADDR_WIDTH-1:0] word;
  logic                    bad;
  logic                    unused_prot;

  assign unused_prot = ^prot[2:1];

  always_comb begin
    offset = addr - P_BASE_ADDR;
    word   = offset >> LSB;
    // Below-base check must use the raw address: the subtraction wraps.
    bad    = (addr < P_BASE_ADDR) ||
             (word >= P_ADDR_WIDTH'(P_DEPTH)) ||
             (offset[LSB-1:0] != '0) ||
             ((P_PROT_CHECK != 0) && !prot[0]);
    index  = word[IDX_W-1:0];
    resp   = bad ? SLVERR : OKAY;
  end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave RAM with independent write/read FSMs, programmable response latency and SLVERR decode.
module axi4_lite_slave_mem
  import axi4_lite_pkg::*;
#(
  parameter int                      P_DATA_WIDTH = 32,
  parameter int                      P_ADDR_WIDTH = 32,
  parameter int                      P_DEPTH      = 256,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE_ADDR  = '0,
  parameter int                      P_WR_WAIT    = 0,
  parameter int                      P_RD_WAIT    = 0,
  parameter int                      P_PROT_CHECK = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [P_ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [P_DATA_WIDTH-1:0]   wdata,
  input  logic [P_DATA_WIDTH/8-1:0] wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [P_ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [P_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                rresp
);
  localparam int STRB_W = P_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(P_DEPTH);

  logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];

  wr_state_t               wr_state;
  logic                    aw_got, w_got;
  logic [P_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]              aw_prot;
  logic [P_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]       w_strb;
  logic [3:0]              wr_cnt;
  logic [IDX_W-1:0]        wr_index;
  resp_t                   wr_resp;
  logic                    wr_commit, wr_enter_resp;

  rd_state_t               rd_state;
  logic                    ar_got;
  logic [P_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]              ar_prot;
  logic [3:0]              rd_cnt;
  logic [IDX_W-1:0]        rd_index;
  resp_t                   rd_resp;
  logic                    rd_start, rd_enter_resp;

  axi4_lite_addr_decode #(
    .P_DATA_WIDTH(P_DATA_WIDTH), .P_ADDR_WIDTH(P_ADDR_WIDTH), .P_DEPTH(P_DEPTH),
    .P_BASE_ADDR(P_BASE_ADDR), .P_PROT_CHECK(P_PROT_CHECK)
  ) u_wr_decode (
    .addr(aw_addr), .prot(aw_prot), .index(wr_index), .resp(wr_resp)
  );

  axi4_lite_addr_decode #(
    .P_DATA_WIDTH(P_DATA_WIDTH), .P_ADDR_WIDTH(P_ADDR_WIDTH), .P_DEPTH(P_DEPTH),
    .P_BASE_ADDR(P_BASE_ADDR), .P_PROT_CHECK(P_PROT_CHECK)
  ) u_rd_decode (
    .addr(ar_addr), .prot(ar_prot), .index(rd_index), .resp(rd_resp)
  );

  // Commit happens the cycle after the later of the AW/W handshakes, from captured values.
  assign wr_commit     = (wr_state == WR_IDLE) && aw_got && w_got;
  assign wr_enter_resp = (wr_commit && (P_WR_WAIT == 0)) ||
                         ((wr_state == WR_WAIT) && (wr_cnt == 4'(P_WR_WAIT)));
  assign rd_start      = (rd_state == RD_IDLE) && ar_got;
  assign rd_enter_resp = (rd_start && (P_RD_WAIT == 0)) ||
                         ((rd_state == RD_WAIT) && (rd_cnt == 4'(P_RD_WAIT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
    end else if (wr_commit && (wr_resp == OKAY)) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_strb[b]) mem[wr_index][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      wr_cnt   <= '0;
      aw_addr  <= '0;
      aw_prot  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else if (wr_enter_resp) begin
      if (wr_commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bresp  <= wr_resp;
      end
      wr_state <= WR_RESP;
      bvalid   <= 1'b1;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_commit) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bresp    <= wr_resp;
            wr_cnt   <= 4'd1;
            wr_state <= WR_WAIT;
          end else begin
            if (awvalid && awready) begin
              aw_got  <= 1'b1;
              awready <= 1'b0;
              aw_addr <= awaddr;
              aw_prot <= awprot;
            end else if (!aw_got) begin
              awready <= 1'b1;
            end
            if (wvalid && wready) begin
              w_got  <= 1'b1;
              wready <= 1'b0;
              w_data <= wdata;
              w_strb <= wstrb;
            end else if (!w_got) begin
              wready <= 1'b1;
            end
          end
        end
        WR_WAIT: wr_cnt <= wr_cnt + 4'd1;
        WR_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Memory is sampled here on the same edge a write may commit, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      ar_got   <= 1'b0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rresp    <= OKAY;
      rdata    <= '0;
      rd_cnt   <= '0;
      ar_addr  <= '0;
      ar_prot  <= '0;
    end else if (rd_enter_resp) begin
      ar_got   <= 1'b0;
      rvalid   <= 1'b1;
      rresp    <= rd_resp;
      rdata    <= (rd_resp == OKAY) ? mem[rd_index] : '0;
      rd_state <= RD_RESP;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            ar_got   <= 1'b0;
            rd_cnt   <= 4'd1;
            rd_state <= RD_WAIT;
          end else if (arvalid && arready) begin
            ar_got  <= 1'b1;
            arready <= 1'b0;
            ar_addr <= araddr;
            ar_prot <= arprot;
          end else if (!ar_got) begin
            arready <= 1'b1;
          end
        end
        RD_WAIT: rd_cnt <= rd_cnt + 4'd1;
        RD_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            rdata    <= '0;
            arready  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
